// File: rtl/dlx_pkg.sv
// +----------------------------------------------------------------------+
// | dlx_pkg                                                              |
// | Shared DLX control-bit indices and MEM-stage state encoding.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package dlx_pkg;

  localparam int MEM_READ    = 0;
  localparam int MEM_WRITE   = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout_counter.sv
// +----------------------------------------------------------------------+
// | mem_timeout_counter                                                  |
// | Wait-cycle counter with clear/enable and terminal-count flag.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_terminal = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------+
// | mem_access_unit                                                      |
// | DLX memory stage: req/ack data-memory access, pipeline stall and     |
// | MEM/WB result latch.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import dlx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  M_control_in,
  input  logic [1:0]  WB_control_in,
  input  logic [31:0] ALU_out_in,
  input  logic [31:0] data_write_in,
  input  logic [4:0]  rw_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  input  logic        bus_error_clr,
  output logic        stall,
  output logic        bus_error,
  output logic [1:0]  WB_control_out,
  output logic [31:0] ALU_out_out,
  output logic [31:0] mem_data_out,
  output logic [4:0]  rw_out
);

  logic [0:0] r_state;
  logic       w_busy;
  logic       w_access;
  logic       w_misaligned;
  logic       w_terminal;
  logic       w_timeout;
  logic       w_issue;
  logic       w_align_err;
  logic       w_done;
  logic       w_abort;

  assign w_busy       = (r_state == BUSY);
  assign w_access     = M_control_in[MEM_READ] | M_control_in[MEM_WRITE];
  assign w_misaligned = is_misaligned(ALU_out_in);
  assign w_timeout    = w_busy & w_terminal;
  assign w_issue      = ~w_busy & w_access & ~w_misaligned;
  assign w_align_err  = ~w_busy & w_access & w_misaligned;
  // Ack beats a same-cycle timeout, so only an unacknowledged timeout aborts.
  assign w_done       = w_busy & dmem_ack;
  assign w_abort      = w_timeout & ~dmem_ack;

  assign stall = reset_n & (w_issue | (w_busy & ~dmem_ack & ~w_timeout));

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clear   (~w_busy),
    .i_enable  (w_busy),
    .o_terminal(w_terminal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state    <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= M_control_in[MEM_WRITE];
            dmem_addr  <= {ALU_out_in[31:2], 2'b00};
            dmem_wdata <= data_write_in;
          end
        end
        BUSY: begin
          if (dmem_ack || w_timeout) begin
            r_state  <= IDLE;
            dmem_req <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_error <= 1'b0;
    end else if (w_align_err || w_abort) begin
      bus_error <= 1'b1;
    end else if (bus_error_clr) begin
      bus_error <= 1'b0;
    end
  end

  // Anything other than a completed access or a plain ALU op becomes a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      WB_control_out <= '0;
      ALU_out_out    <= '0;
      mem_data_out   <= '0;
      rw_out         <= '0;
    end else if (w_done) begin
      WB_control_out <= WB_control_in;
      ALU_out_out    <= ALU_out_in;
      rw_out         <= rw_in;
      mem_data_out   <= dmem_we ? 32'h0 : dmem_rdata;
    end else if (!w_busy && !w_access) begin
      WB_control_out <= WB_control_in;
      ALU_out_out    <= ALU_out_in;
      rw_out         <= rw_in;
      mem_data_out   <= 32'h0;
    end else begin
      WB_control_out <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------+
// | tb_mem_access_unit                                                   |
// | Scoreboard bench for mem_access_unit with a latency-programmable     |
// | memory responder.                                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

  logic        clock;
  logic        reset_n;
  logic [1:0]  M_control_in;
  logic [1:0]  WB_control_in;
  logic [31:0] ALU_out_in;
  logic [31:0] data_write_in;
  logic [4:0]  rw_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        bus_error_clr;
  logic        stall;
  logic        bus_error;
  logic [1:0]  WB_control_out;
  logic [31:0] ALU_out_out;
  logic [31:0] mem_data_out;
  logic [4:0]  rw_out;

  mem_access_unit #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .M_control_in  (M_control_in),
    .WB_control_in (WB_control_in),
    .ALU_out_in    (ALU_out_in),
    .data_write_in (data_write_in),
    .rw_in         (rw_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .bus_error_clr (bus_error_clr),
    .stall         (stall),
    .bus_error     (bus_error),
    .WB_control_out(WB_control_out),
    .ALU_out_out   (ALU_out_out),
    .mem_data_out  (mem_data_out),
    .rw_out        (rw_out)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rw;
  } wb_t;

  wb_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // responder configuration (stimulus writes, responder reads)
  bit          resp_en      = 1'b1;
  int          resp_delay   = 0;
  logic [31:0] resp_rdata   = 32'h0;
  logic        manual_ack   = 1'b0;
  logic [31:0] manual_rdata = 32'h0;

  // expected bus values while dmem_req is high
  logic [31:0] exp_addr  = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic        exp_we    = 1'b0;

  int stall_tot = 0, req_tot = 0, we_tot = 0, unstable_tot = 0, gap_viol = 0;
  int s_stall, s_req, s_we, s_unst;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory responder: ack after resp_delay wait cycles of dmem_req
  initial begin : responder
    int wait_cnt;
    wait_cnt   = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (!resp_en) begin
        dmem_ack   = manual_ack;
        dmem_rdata = manual_rdata;
        wait_cnt   = 0;
      end else if (dmem_req) begin
        if (wait_cnt >= resp_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = resp_rdata;
          wait_cnt   = 0;
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = 32'h0;
          wait_cnt++;
        end
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        wait_cnt   = 0;
      end
    end
  end

  // per-cycle activity counters
  initial begin : activity
    bit prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (reset_n) begin
        if (stall) stall_tot++;
        if (dmem_req) begin
          req_tot++;
          if (dmem_we) we_tot++;
          if (dmem_addr !== exp_addr || dmem_wdata !== exp_wdata || dmem_we !== exp_we)
            unstable_tot++;
          if (prev_ack) gap_viol++;
        end
        prev_ack = dmem_ack;
      end else begin
        prev_ack = 1'b0;
      end
    end
  end

  // scoreboard monitor: every non-zero WB capture must match the next expected entry
  initial begin : monitor
    bit  prev_stall;
    wb_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (reset_n) begin
        if (prev_stall) check("bubble_after_stall", {30'b0, WB_control_out}, 32'h0);
        if (WB_control_out != 2'b00) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_wb: actual WB=%b alu=0x%08h rw=%0d, required none", WB_control_out, ALU_out_out, rw_out);
          end else begin
            e = exp_q.pop_front();
            check("wb_ctrl", {30'b0, WB_control_out}, {30'b0, e.wb});
            check("wb_alu", ALU_out_out, e.alu);
            check("wb_mem", mem_data_out, e.mem);
            check("wb_rw", {27'b0, rw_out}, {27'b0, e.rw});
          end
        end
        prev_stall = stall;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic set_nop();
    M_control_in  = 2'b00;
    WB_control_in = 2'b00;
    ALU_out_in    = 32'h0;
    data_write_in = 32'h0;
    rw_in         = 5'd0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    set_nop();
  endtask

  task automatic snap();
    s_stall = stall_tot;
    s_req   = req_tot;
    s_we    = we_tot;
    s_unst  = unstable_tot;
  endtask

  // present one instruction at the EX_MEM outputs and hold it until it is not stalled
  task automatic issue(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                       input logic [31:0] wdata, input logic [4:0] rw, input int delay,
                       input logic [31:0] rdata, input bit expect_wb);
    @(posedge clock);
    #1;
    WB_control_in = wb;
    M_control_in  = m;
    ALU_out_in    = alu;
    data_write_in = wdata;
    rw_in         = rw;
    resp_delay    = delay;
    resp_rdata    = rdata;
    if (m != 2'b00 && alu[1:0] == 2'b00) begin
      exp_addr  = alu;
      exp_wdata = wdata;
      exp_we    = m[1];
    end
    if (expect_wb)
      exp_q.push_back('{wb: wb, alu: alu, mem: (m != 2'b00 && !m[1]) ? rdata : 32'h0, rw: rw});
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      #3;
      if (!stall) break;
      if (n == 39) begin
        vectors++;
        miscompares++;
        $display("FAIL stall_bound: stall still 1 after 40 cycles, required release");
      end
    end
  endtask

  task automatic clear_error();
    @(posedge clock);
    #1;
    bus_error_clr = 1'b1;
    @(posedge clock);
    #1;
    bus_error_clr = 1'b0;
    @(negedge clock);
    #3;
    check("bus_error_cleared", {31'b0, bus_error}, 32'h0);
  endtask

  initial begin : stimulus
    reset_n       = 1'b0;
    bus_error_clr = 1'b0;
    M_control_in  = 2'b01;
    WB_control_in = 2'b11;
    ALU_out_in    = 32'h10;
    data_write_in = 32'h0;
    rw_in         = 5'd5;

    // reset state, with a pending load at the inputs
    @(negedge clock);
    #3;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_req", {31'b0, dmem_req}, 32'h0);
    check("rst_we", {31'b0, dmem_we}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_bus_error", {31'b0, bus_error}, 32'h0);
    check("rst_wb_ctrl", {30'b0, WB_control_out}, 32'h0);
    check("rst_mem_data", mem_data_out, 32'h0);
    @(posedge clock);
    #1;
    set_nop();
    reset_n = 1'b1;

    // load, ack on first BUSY cycle
    snap();
    issue(2'b11, 2'b01, 32'h0000_0010, 32'h0, 5'd5, 0, 32'hDEAD_BEEF, 1'b1);
    step();
    @(negedge clock);
    #3;
    check("load_stall_cycles", stall_tot - s_stall, 32'd1);
    check("load_req_cycles", req_tot - s_req, 32'd1);
    check("load_mem_data", mem_data_out, 32'hDEAD_BEEF);
    check("load_rw", {27'b0, rw_out}, 32'd5);

    // store, 3 wait cycles
    snap();
    issue(2'b01, 2'b10, 32'h0000_0020, 32'h1234_5678, 5'd0, 3, 32'hFFFF_FFFF, 1'b1);
    step();
    @(negedge clock);
    #3;
    check("store_stall_cycles", stall_tot - s_stall, 32'd4);
    check("store_req_cycles", req_tot - s_req, 32'd4);
    check("store_we_cycles", we_tot - s_we, 32'd4);
    check("store_bus_unstable", unstable_tot - s_unst, 32'd0);
    check("store_mem_data", mem_data_out, 32'h0);

    // misaligned load
    snap();
    issue(2'b11, 2'b01, 32'h0000_0013, 32'h0, 5'd7, 0, 32'h5555_5555, 1'b0);
    step();
    @(negedge clock);
    #3;
    check("misalign_bus_error", {31'b0, bus_error}, 32'h1);
    check("misalign_wb_bubble", {30'b0, WB_control_out}, 32'h0);
    check("misalign_req_cycles", req_tot - s_req, 32'd0);
    check("misalign_stall_cycles", stall_tot - s_stall, 32'd0);
    clear_error();

    // timeout, no ack
    snap();
    issue(2'b11, 2'b01, 32'h0000_0040, 32'h0, 5'd9, 100, 32'h0, 1'b0);
    step();
    @(negedge clock);
    #3;
    check("timeout_req_cycles", req_tot - s_req, 32'd4);
    check("timeout_stall_cycles", stall_tot - s_stall, 32'd4);
    check("timeout_bus_error", {31'b0, bus_error}, 32'h1);
    check("timeout_wb_bubble", {30'b0, WB_control_out}, 32'h0);
    check("timeout_req_dropped", {31'b0, dmem_req}, 32'h0);
    clear_error();

    // ack on the same cycle the counter expires
    snap();
    issue(2'b11, 2'b01, 32'h0000_0044, 32'h0, 5'd10, 3, 32'h0BAD_F00D, 1'b1);
    step();
    @(negedge clock);
    #3;
    check("lateack_req_cycles", req_tot - s_req, 32'd4);
    check("lateack_stall_cycles", stall_tot - s_stall, 32'd4);
    check("lateack_bus_error", {31'b0, bus_error}, 32'h0);
    check("lateack_mem_data", mem_data_out, 32'h0BAD_F00D);

    // mixed ALU ops and loads, including back-to-back loads
    issue(2'b10, 2'b00, 32'h0000_0004, 32'h0, 5'd1, 0, 32'h0, 1'b1);
    issue(2'b11, 2'b01, 32'h0000_0100, 32'h0, 5'd2, 1, 32'hA1A1_A1A1, 1'b1);
    issue(2'b11, 2'b01, 32'h0000_0104, 32'h0, 5'd3, 0, 32'hB2B2_B2B2, 1'b1);
    issue(2'b10, 2'b00, 32'h0000_0008, 32'h0, 5'd4, 0, 32'h0, 1'b1);
    issue(2'b11, 2'b01, 32'h0000_0100, 32'h0, 5'd5, 2, 32'hC3C3_C3C3, 1'b1);
    issue(2'b10, 2'b00, 32'h0000_0004, 32'h0, 5'd6, 0, 32'h0, 1'b1);

    // reset asserted while BUSY
    @(posedge clock);
    #1;
    resp_en       = 1'b0;
    manual_ack    = 1'b0;
    WB_control_in = 2'b11;
    M_control_in  = 2'b01;
    ALU_out_in    = 32'h0000_0200;
    data_write_in = 32'h0;
    rw_in         = 5'd12;
    exp_addr      = 32'h0000_0200;
    exp_wdata     = 32'h0;
    exp_we        = 1'b0;
    @(negedge clock);
    #3;
    @(negedge clock);
    #3;
    check("busy_before_reset_req", {31'b0, dmem_req}, 32'h1);
    check("busy_before_reset_stall", {31'b0, stall}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_req", {31'b0, dmem_req}, 32'h0);
    check("async_reset_stall", {31'b0, stall}, 32'h0);
    check("async_reset_alu", ALU_out_out, 32'h0);
    check("async_reset_rw", {27'b0, rw_out}, 32'h0);
    set_nop();
    @(posedge clock);
    #1;
    reset_n      = 1'b1;
    manual_ack   = 1'b1;
    manual_rdata = 32'hCAFE_F00D;
    @(posedge clock);
    #1;
    manual_ack = 1'b0;
    @(negedge clock);
    #3;
    check("post_reset_ack_mem", mem_data_out, 32'h0);
    check("post_reset_ack_wb", {30'b0, WB_control_out}, 32'h0);
    check("post_reset_ack_req", {31'b0, dmem_req}, 32'h0);
    check("post_reset_bus_error", {31'b0, bus_error}, 32'h0);
    resp_en = 1'b1;

    step();
    step();
    @(negedge clock);
    #3;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("req_gap_violations", gap_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
